// File: rtl/otter_hazard_unit_if.sv
// otter_hazard_unit_if: decoder register-usage inputs and pipeline control / forwarding outputs
interface otter_hazard_unit_if;
  logic        ID_VALID;
  logic [4:0]  ID_RS1_ADDR;
  logic [4:0]  ID_RS2_ADDR;
  logic [4:0]  ID_RD_ADDR;
  logic        ID_RS1_USED;
  logic        ID_RS2_USED;
  logic        ID_RD_USED;
  logic        ID_MEMREAD2;
  logic        EX_BRANCH_TAKEN;
  logic        STALL_IF;
  logic        STALL_ID;
  logic        BUBBLE_EX;
  logic        FLUSH_ID;
  logic [1:0]  FWD_A_SEL;
  logic [1:0]  FWD_B_SEL;
  logic [15:0] STALL_CNT;
  modport master (
    output ID_VALID, ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR,
    output ID_RS1_USED, ID_RS2_USED, ID_RD_USED, ID_MEMREAD2, EX_BRANCH_TAKEN,
    input  STALL_IF, STALL_ID, BUBBLE_EX, FLUSH_ID, FWD_A_SEL, FWD_B_SEL, STALL_CNT
  );
  modport slave (
    input  ID_VALID, ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR,
    input  ID_RS1_USED, ID_RS2_USED, ID_RD_USED, ID_MEMREAD2, EX_BRANCH_TAKEN,
    output STALL_IF, STALL_ID, BUBBLE_EX, FLUSH_ID, FWD_A_SEL, FWD_B_SEL, STALL_CNT
  );
endinterface

// File: rtl/otter_hazard_unit.sv
// otter_hazard_unit: EX/MEM/WB scoreboard driving stall, bubble, flush and forwarding controls.
// Define OTTER_FORWARD_EN for forwarding (load-use stalls only); otherwise RAW hazards stall.
module otter_hazard_unit #(
  parameter bit RF_WRITE_THROUGH = 1'b1
) (
  input logic                CLK,
  input logic                RST_N,
  otter_hazard_unit_if.slave hz
);
  typedef struct packed {
    logic       occ;
    logic       wr;
    logic [4:0] rd;
  } rec_t;
  rec_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        use1, use2, stall, flush, bubble, stall_id;
  function automatic logic hit(rec_t r, logic [4:0] rs, logic used);
    return used & r.occ & r.wr & (r.rd == rs);
  endfunction
  function automatic logic hit2(rec_t r, logic [4:0] a1, logic u1, logic [4:0] a2, logic u2);
    return hit(r, a1, u1) | hit(r, a2, u2);
  endfunction
  assign use1  = hz.ID_VALID & hz.ID_RS1_USED;
  assign use2  = hz.ID_VALID & hz.ID_RS2_USED;
  assign flush = hz.EX_BRANCH_TAKEN & ex_q.occ;
`ifdef OTTER_FORWARD_EN
  logic       ex_ld_q, ex_ld_d, ex_u1_q, ex_u1_d, ex_u2_q, ex_u2_d;
  logic [4:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic       unused_wt;
  assign unused_wt = RF_WRITE_THROUGH;
  assign stall = ex_ld_q & hit2(ex_q, hz.ID_RS1_ADDR, use1, hz.ID_RS2_ADDR, use2);
  // MEM never holds a load feeding EX: the load-use stall guarantees a bubble between them
  always_comb begin
    ex_ld_d      = bubble ? 1'b0 : hz.ID_MEMREAD2;
    ex_rs1_d     = bubble ? 5'd0 : hz.ID_RS1_ADDR;
    ex_rs2_d     = bubble ? 5'd0 : hz.ID_RS2_ADDR;
    ex_u1_d      = bubble ? 1'b0 : use1;
    ex_u2_d      = bubble ? 1'b0 : use2;
    hz.FWD_A_SEL = hit(mem_q, ex_rs1_q, ex_u1_q) ? 2'd1 : hit(wb_q, ex_rs1_q, ex_u1_q) ? 2'd2 : 2'd0;
    hz.FWD_B_SEL = hit(mem_q, ex_rs2_q, ex_u2_q) ? 2'd1 : hit(wb_q, ex_rs2_q, ex_u2_q) ? 2'd2 : 2'd0;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {ex_ld_q, ex_rs1_q, ex_rs2_q, ex_u1_q, ex_u2_q} <= '0;
    end else begin
      {ex_ld_q, ex_rs1_q, ex_rs2_q, ex_u1_q, ex_u2_q} <= {ex_ld_d, ex_rs1_d, ex_rs2_d, ex_u1_d, ex_u2_d};
    end
  end
`else
  logic unused_ld;
  assign unused_ld    = hz.ID_MEMREAD2;
  assign stall        = hit2(ex_q, hz.ID_RS1_ADDR, use1, hz.ID_RS2_ADDR, use2)
                      | hit2(mem_q, hz.ID_RS1_ADDR, use1, hz.ID_RS2_ADDR, use2)
                      | (!RF_WRITE_THROUGH & hit2(wb_q, hz.ID_RS1_ADDR, use1, hz.ID_RS2_ADDR, use2));
  assign hz.FWD_A_SEL = 2'd0;
  assign hz.FWD_B_SEL = 2'd0;
`endif
  always_comb begin
    bubble       = stall | flush;
    stall_id     = stall & ~flush;
    hz.STALL_IF  = stall_id;
    hz.STALL_ID  = stall_id;
    hz.BUBBLE_EX = bubble;
    hz.FLUSH_ID  = flush;
    hz.STALL_CNT = stall_cnt_q;
    ex_d         = bubble ? '0 : {hz.ID_VALID, hz.ID_VALID & hz.ID_RD_USED, hz.ID_RD_ADDR};
    mem_d        = ex_q;
    wb_d         = mem_q;
    stall_cnt_d  = (stall_id & ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_otter_hazard_unit.sv
// tb_otter_hazard_unit: directed and random stimulus against an in-flight instruction model
module tb_otter_hazard_unit;
  localparam bit WT = 1'b1;
`ifdef OTTER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    bit occ; bit wr; bit ld; int rd; int rs1; int rs2; bit u1; bit u2; bit br;
  } ins_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_err = 0;
  ins_t cur, pipe[3];
  int   m_cnt = 0, c0, n;
  bit   e_stall, e_flush, e_sid, e_bub;
  int   e_fa, e_fb;
  otter_hazard_unit_if hz();
  otter_hazard_unit #(.RF_WRITE_THROUGH(WT)) dut (.CLK(clk), .RST_N(rst_n), .hz(hz));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ins_t blank();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction
  // source stage of a forwarded operand = pipeline distance of the youngest older writer
  function automatic int fwd_src(int rs, bit u);
    if (!FWD || !u) return 0;
    for (int s = 1; s < 3; s++)
      if (pipe[s].occ && pipe[s].wr && pipe[s].rd == rs) return s;
    return 0;
  endfunction
  task automatic drive(bit v, int rs1, int rs2, int rd, bit ld, bit br);
    cur = '{occ: v, wr: v && rd != 0, ld: v && ld, rd: rd, rs1: rs1, rs2: rs2,
            u1: v && rs1 != 0, u2: v && rs2 != 0, br: br};
    hz.ID_VALID        = v;
    hz.ID_RS1_ADDR     = 5'(rs1);
    hz.ID_RS2_ADDR     = 5'(rs2);
    hz.ID_RD_ADDR      = 5'(rd);
    hz.ID_RS1_USED     = cur.u1;
    hz.ID_RS2_USED     = cur.u2;
    hz.ID_RD_USED      = cur.wr;
    hz.ID_MEMREAD2     = cur.ld;
    hz.EX_BRANCH_TAKEN = br;
  endtask
  task automatic sample();
    @(negedge clk);
    if (!rst_n) begin
      foreach (pipe[s]) pipe[s] = blank();
      m_cnt = 0;
    end
    e_stall = 0;
    for (int s = 0; s < 3; s++) begin
      bit h;
      h = pipe[s].occ && pipe[s].wr &&
          ((cur.u1 && pipe[s].rd == cur.rs1) || (cur.u2 && pipe[s].rd == cur.rs2));
      if (h && (FWD ? (s == 0 && pipe[s].ld) : (s < (WT ? 2 : 3)))) e_stall = 1;
    end
    e_flush = cur.br && pipe[0].occ;
    e_bub   = e_stall || e_flush;
    e_sid   = e_stall && !e_flush;
    e_fa    = fwd_src(pipe[0].rs1, pipe[0].u1);
    e_fb    = fwd_src(pipe[0].rs2, pipe[0].u2);
    chk("stall_if", hz.STALL_IF, e_sid);
    chk("stall_id", hz.STALL_ID, e_sid);
    chk("bubble_ex", hz.BUBBLE_EX, e_bub);
    chk("flush_id", hz.FLUSH_ID, e_flush);
    chk("fwd_a", hz.FWD_A_SEL, e_fa);
    chk("fwd_b", hz.FWD_B_SEL, e_fb);
    chk("stall_cnt", hz.STALL_CNT, m_cnt);
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (e_sid && m_cnt < 'hFFFF) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e_bub ? blank() : cur;
    end
    #1;
  endtask
  task automatic step();
    sample();
    tick();
  endtask
  task automatic nops(int k);
    drive(0, 0, 0, 0, 0, 0);
    repeat (k) step();
  endtask
  initial begin
    drive(1, 5, 5, 5, 1, 1);
    repeat (2) begin
      sample();
      chk("rst_stall_id", hz.STALL_ID, 0);
      chk("rst_bubble", hz.BUBBLE_EX, 0);
      chk("rst_cnt", hz.STALL_CNT, 0);
      tick();
    end
    rst_n = 1'b1;
    nops(1);
    // producer x5 followed by a consumer of x5
    drive(1, 0, 0, 5, 0, 0); step();
    drive(1, 5, 0, 6, 0, 0); sample();
    chk("alu_stall", hz.STALL_ID, FWD ? 0 : 1);
    tick();
    drive(0, 0, 0, 0, 0, 0); sample();
    chk("alu_fwd_a", hz.FWD_A_SEL, FWD ? 1 : 0);
    tick();
    nops(3);
    // load then dependent add on both sources
    drive(1, 0, 0, 5, 1, 0); step();
    drive(1, 5, 5, 6, 0, 0); sample();
    chk("lu_stall_if", hz.STALL_IF, 1);
    chk("lu_stall_id", hz.STALL_ID, 1);
    chk("lu_bubble", hz.BUBBLE_EX, 1);
    c0 = m_cnt;
    tick();
    sample();
    chk("lu_cnt", hz.STALL_CNT, c0 + 1);
    chk("lu_second", hz.STALL_ID, FWD ? 0 : 1);
    tick();
    drive(0, 0, 0, 0, 0, 0); sample();
    chk("lu_fwd_a", hz.FWD_A_SEL, FWD ? 2 : 0);
    chk("lu_fwd_b", hz.FWD_B_SEL, FWD ? 2 : 0);
    tick();
    nops(3);
    // taken branch while a load sits in EX and its consumer in ID
    drive(1, 0, 0, 5, 1, 0); step();
    drive(1, 5, 0, 6, 0, 1); sample();
    chk("fl_flush", hz.FLUSH_ID, 1);
    chk("fl_bubble", hz.BUBBLE_EX, 1);
    chk("fl_stall_id", hz.STALL_ID, 0);
    chk("fl_stall_if", hz.STALL_IF, 0);
    c0 = m_cnt;
    tick();
    drive(0, 0, 0, 0, 0, 0); sample();
    chk("fl_cnt", hz.STALL_CNT, c0);
    tick();
    nops(3);
    // asynchronous reset in the middle of a hazard
    drive(1, 0, 0, 5, 1, 0); step();
    drive(1, 5, 5, 6, 0, 1);
    rst_n = 1'b0;
    sample();
    chk("rst2_stall_id", hz.STALL_ID, 0);
    chk("rst2_flush", hz.FLUSH_ID, 0);
    chk("rst2_bubble", hz.BUBBLE_EX, 0);
    chk("rst2_cnt", hz.STALL_CNT, 0);
    tick();
    rst_n = 1'b1;
    sample();
    chk("rst_rel_stall", hz.STALL_ID, 0);
    tick();
    nops(3);
    // RAW stall length: add x5 then sub x7,x5
    drive(1, 0, 0, 5, 0, 0); step();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 5, 0, 7, 0, 0);
      sample();
      if (hz.STALL_ID !== 1'b1) break;
      n++;
      tick();
    end
    tick();
    chk("raw_stalls", n, FWD ? 0 : (WT ? 2 : 3));
    drive(0, 0, 0, 0, 0, 0); sample();
    chk("raw_fwd_a", hz.FWD_A_SEL, FWD ? 1 : 0);
    tick();
    nops(3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      step();
      rst_n = 1'b1;
    end
    nops(3);
    // preload the counter near its limit, then keep stalling past it
    force dut.stall_cnt_q = 16'hFFF0;
    m_cnt = 'hFFF0;
    #1 release dut.stall_cnt_q;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 5, 1, 0); step();
      for (int j = 0; j < 4; j++) begin
        drive(1, 5, 0, 6, 0, 0);
        sample();
        if (!e_sid) break;
        tick();
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0); sample();
    chk("sat_cnt", hz.STALL_CNT, 16'hFFFF);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/otter_hazard_unit.md
# otter_hazard_unit

Pipeline hazard unit for the 5-stage OTTER RV32I core (IF, ID, EX, MEM, WB). It sits beside the decode stage and consumes the decoder's register-usage outputs (RS1/RS2/RD addresses and used flags, load indication) every cycle. It keeps its own scoreboard of the instructions in flight in EX, MEM and WB, and from it produces:
- stall and bubble controls for load-use and RAW hazards;
- flush control for taken branches;
- EX-stage operand forwarding selects;
- a saturating stall-cycle counter.

## Interface
Parameters
- RF_WRITE_THROUGH, default 1: register file bypasses same-cycle WB write to readers; when 0, WB-stage producers also cause hazards.

Ports (clock and reset: one clock, CLK; reset RST_N is asynchronous, active-low)
- CLK  in  1  core clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- ID_VALID  in  1  decode stage holds a valid instruction
- ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR  in  5 each  decoded register addresses
- ID_RS1_USED, ID_RS2_USED, ID_RD_USED  in  1 each  decoder usage flags (already false for x0)
- ID_MEMREAD2  in  1  decode-stage instruction is a load
- EX_BRANCH_TAKEN  in  1  EX-stage branch/jump redirects PC this cycle
- STALL_IF  out  1  hold PC
- STALL_ID  out  1  hold IF/ID register
- BUBBLE_EX  out  1  load NOP into ID/EX instead of decode instruction
- FLUSH_ID  out  1  invalidate IF/ID register
- FWD_A_SEL, FWD_B_SEL  out  2 each  EX operand source: 0 regfile, 1 EX/MEM ALU result, 2 MEM/WB write data, 3 unused
- STALL_CNT  out  16  saturating count of stalled cycles

## Operation
- Scoreboard records EX, MEM, WB; each record holds occ (instruction present), wr (writes rd), rd, ld (is load), plus rs1/rs2 addresses and used flags (EX record only).
- Each edge: WB <= MEM, MEM <= EX. EX <= decode fields (occ=ID_VALID, wr=ID_VALID&ID_RD_USED, ld=ID_MEMREAD2) unless BUBBLE_EX, in which case EX <= empty record.
- hit(rec, rs) = rec.occ & rec.wr & rec.rd==rs, evaluated for each ID source with its USED flag and ID_VALID.
- Forwarding mode: load-use stall when hit(EX, rs) & EX.ld for either source.
- Non-forwarding mode: stall when hit(EX) or hit(MEM), or hit(WB) when RF_WRITE_THROUGH=0.
- Stall: STALL_IF=STALL_ID=BUBBLE_EX=1.
- Flush: when EX_BRANCH_TAKEN & EX.occ: FLUSH_ID=1, BUBBLE_EX=1, STALL_IF=STALL_ID=0. Flush overrides stall in the same cycle.
- FWD_x_SEL, forwarding mode only: computed from the EX record's rs and used flag. Priority: 1 if it hits MEM (MEM.ld never hits, guaranteed by load-use stall), else 2 if it hits WB, else 0.
- STALL_CNT increments on each edge where STALL_ID=1; saturates at 0xFFFF.

## Timing
- All outputs combinational from current inputs and registered scoreboard; no input-to-state combinational loops.
- Reset (RST_N low, async): all records empty, STALL_CNT=0. Consequently all outputs are 0 regardless of ID inputs.
- Load-use stall lasts exactly 1 cycle. The bubble then occupies EX and the load moves to MEM, where forwarding selects 2 next cycle.
- Non-forwarding RAW stall lasts until the producer leaves the last hazard stage: up to 2 cycles, or 3 when RF_WRITE_THROUGH=0.
- Reset deassertion mid-stall: the next cycle starts from the empty scoreboard with no stall.

## Configuration
- OTTER_FORWARD_EN defined: forwarding paths active; only load-use stalls.
- Undefined: FWD_A_SEL=FWD_B_SEL=0 always; forwarding logic not compiled; RAW stall rule above applies.

## Test plan
- Reset: hold RST_N=0 with ID_VALID=1, RS1 hit pattern present -> all outputs 0, STALL_CNT=0.
- FWD on, add x5 then add x6,x5 -> no stall; next cycle FWD_A_SEL=1.
- FWD on, lw x5 then add x6,x5,x5 -> one cycle STALL_IF/STALL_ID/BUBBLE_EX=1, STALL_CNT=1; then FWD_A_SEL=FWD_B_SEL=2.
- Flush: lw x5 in EX, consumer in ID, EX_BRANCH_TAKEN=1 -> FLUSH_ID=1, BUBBLE_EX=1, STALL_ID=0, STALL_CNT unchanged.
- FWD off, RF_WRITE_THROUGH=1: add x5 then sub x7,x5 -> 2 stall cycles, FWD selects 0.
- Saturation: force 70000 stalled cycles -> STALL_CNT holds 0xFFFF.
